fsm_seq_monitor: RTL and testbench
==================================

# fsm_seq_monitor

Receive-side checker for the 4-bit phase-code stream produced by the team's IDLE→S1→S2 sequencer.
- Samples the code each clock and tracks the expected sequence 0→1→2→0.
- Measures how long each phase is held and flags illegal codes, illegal transitions and wrong dwell lengths.
- Counts completed sequences.
- Sits downstream of the sequencer's registered state output, as a self-check and status source.

## Interface
- S1_LEN, 5: required dwell of code 1, in clock cycles (1..255).
- S2_LEN, 7: required dwell of code 2, in clock cycles (1..255).
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- din  input  4  phase code from the sequencer: 0=IDLE, 1=S1, 2=S2; 3..15 are illegal.
- clr  input  1  synchronous clear of seq_cnt and err_code.
- locked  output  1  monitor is synchronised to the sequence.
- seq_done  output  1  one-cycle pulse: a legal 0→1→2→0 sequence has completed.
- err  output  1  one-cycle pulse: protocol violation detected.
- err_code  output  2  cause of the last error, held: 0=illegal code, 1=illegal transition, 2=S1 dwell wrong, 3=S2 dwell wrong.
- seq_cnt  output  8  count of completed sequences, saturating.

## Operation
- Internal registers:
  - prev: last sampled din, 4 bits.
  - dwell: 8-bit count of consecutive edges at which din equalled prev, saturating at 255.
  - monitor FSM state.
- A change at an edge means din ≠ prev. On a change, dwell←1 and prev←din; otherwise dwell←min(dwell+1, 255).
- FSM states:
  - HUNT: locked=0, no error checks. On sampling din==0, go to IDLE.
  - IDLE: expect 0. On change to 1, go to S1. On change to any other value, raise an error.
  - S1: expect 1. On change to 2, check dwell==S1_LEN (old-code dwell, before reload). If equal, go to S2; else raise error code 2. Any other change raises an error.
  - S2: expect 2. On change to 0, check dwell==S2_LEN. If equal, pulse seq_done, increment seq_cnt and go to IDLE; else raise error code 3. Any other change raises an error.
- Error priority when several causes apply at one edge: illegal code (din>2) → 0, then illegal transition → 1, then dwell mismatch → 2/3.
- On any error:
  - err pulses; err_code is loaded with the cause.
  - The FSM goes to HUNT; locked falls.
  - HUNT immediately relocks if the same edge's din is not 0? No: relock is evaluated from the next edge onward.
- locked=1 in IDLE, S1 and S2.
- seq_cnt saturates at 255; no wrap.
- clr wins over a simultaneous seq_done or err:
  - seq_cnt←0 and err_code←0.
  - A seq_done or err pulse at that edge is still emitted.
  - The FSM is unaffected.
- Dwell saturation: a dwell of 255 or more compares as 255, so it mismatches any LEN<255.

## Timing
- Reset values:
  - Outputs: locked=0, seq_done=0, err=0, err_code=0, seq_cnt=0.
  - Internal: prev=0, dwell=0, FSM=HUNT.
- Asynchronous reset mid-sequence discards all progress. After release, the first sampled din==0 relocks.
- All outputs are registered. A condition detected at edge k is visible from edge k until edge k+1.
  - seq_done and err are high for exactly one cycle.
  - seq_cnt and err_code update at the same edge as the pulse.
- Latency: the pulse appears 1 cycle after the sampled din transition (the edge that first sees the new code).
- IDLE dwell is unconstrained (≥1 cycle).
- A glitch of one cycle to a legal but out-of-order code is an illegal transition.

## Test plan
- Sequencer with en held high, 4 full sequences: din = 0 then 1×5, 2×7, repeated (period 13). Required:
  - locked=1 from the edge after the first 0 is sampled.
  - seq_done pulses 4 times, 13 cycles apart.
  - seq_cnt=4; err never asserts.
- S1 held for 6 cycles: err pulses at the 1→2 edge with err_code=2; locked→0; seq_cnt unchanged. After a following legal 0,1×5,2×7,0, seq_done pulses and seq_cnt increments by 1.
- Illegal value: din=9 for one cycle inside S2. Required: err with err_code=0 on that edge (priority over transition). A direct 0→2 jump while locked gives err_code=1.
- Saturation and clear:
  - After 300 legal sequences, seq_cnt=255.
  - Asserting clr on the same edge as a seq_done gives seq_cnt=0, err_code=0, while seq_done still pulses.
- Reset mid-S2 (rst_n low 2 cycles): all outputs return to 0 immediately (asynchronously); locked returns to 1 only after din==0 is sampled post-release.
- Non-default parameters S1_LEN=3, S2_LEN=2 with matching stimulus: legal sequences give no errors; stimulus with S2 dwell 3 gives err_code=3.

Source files
------------

// File: rtl/fsm_seq_monitor.sv
// Receive-side checker for the IDLE->S1->S2 phase-code stream: tracks the
// 0->1->2->0 order, checks S1/S2 dwell lengths and counts completed sequences.
module fsm_seq_monitor #(
    parameter int unsigned S1_LEN = 5,
    parameter int unsigned S2_LEN = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3:0]          din,
    input  logic                clr,
    output logic                locked,
    output logic                seq_done,
    output logic                err,
    output logic [1:0]          err_code,
    output logic [7:0]          seq_cnt
);

    localparam int unsigned DIN_W   = 4;
    localparam int unsigned DWELL_W = 8;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned CODE_W  = 2;

    localparam logic [DWELL_W-1:0] DWELL_MAX = '1;
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
    localparam logic [DWELL_W-1:0] S1_LEN_C  = DWELL_W'(S1_LEN);
    localparam logic [DWELL_W-1:0] S2_LEN_C  = DWELL_W'(S2_LEN);

    localparam logic [DIN_W-1:0] CODE_IDLE = DIN_W'(0);
    localparam logic [DIN_W-1:0] CODE_S1   = DIN_W'(1);
    localparam logic [DIN_W-1:0] CODE_S2   = DIN_W'(2);

    localparam logic [CODE_W-1:0] ERR_ILLEGAL = CODE_W'(0);
    localparam logic [CODE_W-1:0] ERR_TRANS   = CODE_W'(1);
    localparam logic [CODE_W-1:0] ERR_S1_LEN  = CODE_W'(2);
    localparam logic [CODE_W-1:0] ERR_S2_LEN  = CODE_W'(3);

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_IDLE = 2'd1,
        ST_S1   = 2'd2,
        ST_S2   = 2'd3
    } state_t;

    state_t              r_state;
    logic [DIN_W-1:0]    r_prev;
    logic [DWELL_W-1:0]  r_dwell;

    state_t              w_next;
    logic                w_change;
    logic                w_illegal;
    logic                w_err_hit;
    logic [CODE_W-1:0]   w_err_cause;
    logic                w_done_hit;

    assign w_change  = (din != r_prev);
    assign w_illegal = (din > CODE_S2);

    // Transition checks; r_dwell still holds the dwell of the code being left.
    always_comb begin
        w_next      = r_state;
        w_err_hit   = 1'b0;
        w_err_cause = ERR_ILLEGAL;
        w_done_hit  = 1'b0;
        case (r_state)
            ST_HUNT: begin
                if (din == CODE_IDLE) w_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (w_change) begin
                    if (w_illegal) begin
                        w_err_hit   = 1'b1;
                        w_err_cause = ERR_ILLEGAL;
                    end else if (din == CODE_S1) begin
                        w_next = ST_S1;
                    end else begin
                        w_err_hit   = 1'b1;
                        w_err_cause = ERR_TRANS;
                    end
                end
            end
            ST_S1: begin
                if (w_change) begin
                    if (w_illegal) begin
                        w_err_hit   = 1'b1;
                        w_err_cause = ERR_ILLEGAL;
                    end else if (din != CODE_S2) begin
                        w_err_hit   = 1'b1;
                        w_err_cause = ERR_TRANS;
                    end else if (r_dwell != S1_LEN_C) begin
                        w_err_hit   = 1'b1;
                        w_err_cause = ERR_S1_LEN;
                    end else begin
                        w_next = ST_S2;
                    end
                end
            end
            ST_S2: begin
                if (w_change) begin
                    if (w_illegal) begin
                        w_err_hit   = 1'b1;
                        w_err_cause = ERR_ILLEGAL;
                    end else if (din != CODE_IDLE) begin
                        w_err_hit   = 1'b1;
                        w_err_cause = ERR_TRANS;
                    end else if (r_dwell != S2_LEN_C) begin
                        w_err_hit   = 1'b1;
                        w_err_cause = ERR_S2_LEN;
                    end else begin
                        w_done_hit = 1'b1;
                        w_next     = ST_IDLE;
                    end
                end
            end
            default: w_next = ST_HUNT;
        endcase
        if (w_err_hit) w_next = ST_HUNT;
    end

    // State, dwell tracking and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_HUNT;
            r_prev   <= '0;
            r_dwell  <= '0;
            locked   <= 1'b0;
            seq_done <= 1'b0;
            err      <= 1'b0;
            err_code <= '0;
            seq_cnt  <= '0;
        end else begin
            r_prev   <= din;
            r_state  <= w_next;
            locked   <= (w_next != ST_HUNT);
            seq_done <= w_done_hit;
            err      <= w_err_hit;
            if (w_change) begin
                r_dwell <= DWELL_W'(1);
            end else if (r_dwell != DWELL_MAX) begin
                r_dwell <= r_dwell + DWELL_W'(1);
            end
            // Clear takes precedence over the status update of the same edge.
            if (clr) begin
                seq_cnt  <= '0;
                err_code <= '0;
            end else begin
                if (w_err_hit) err_code <= w_err_cause;
                if (w_done_hit && (seq_cnt != CNT_MAX)) seq_cnt <= seq_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fsm_seq_monitor.sv
// Directed bench for fsm_seq_monitor: vector table plus hand-written multi-cycle cases.
module tb_fsm_seq_monitor;

    logic       clk;
    logic       rst_n;
    logic [3:0] din;
    logic       clr;
    logic       locked, seq_done, err;
    logic [1:0] err_code;
    logic [7:0] seq_cnt;

    logic [3:0] din2;
    logic       clr2;
    logic       locked2, seq_done2, err2;
    logic [1:0] err_code2;
    logic [7:0] seq_cnt2;

    fsm_seq_monitor u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .clr      (clr),
        .locked   (locked),
        .seq_done (seq_done),
        .err      (err),
        .err_code (err_code),
        .seq_cnt  (seq_cnt)
    );

    fsm_seq_monitor #(.S1_LEN(3), .S2_LEN(2)) u_dut2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din2),
        .clr      (clr2),
        .locked   (locked2),
        .seq_done (seq_done2),
        .err      (err2),
        .err_code (err_code2),
        .seq_cnt  (seq_cnt2)
    );

    typedef struct {
        logic [3:0] din;
        logic       clr;
        logic       lk;
        logic       dn;
        logic       er;
        logic [1:0] code;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void push(input int n, input logic [3:0] d, input logic c, input logic lk,
                                 input logic dn, input logic er, input logic [1:0] code,
                                 input logic [7:0] cnt);
        vec_t v;
        v.din = d; v.clr = c; v.lk = lk; v.dn = dn; v.er = er; v.code = code; v.cnt = cnt;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endfunction

    function automatic logic [12:0] pack(input logic lk, input logic dn, input logic er,
                                         input logic [1:0] code, input logic [7:0] cnt);
        return {lk, dn, er, code, cnt};
    endfunction

    task automatic cmp(input string name, input int idx, input logic [12:0] act, input logic [12:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got lk=%b done=%b err=%b code=%0d cnt=%0d, want lk=%b done=%b err=%b code=%0d cnt=%0d",
                     name, idx, act[12], act[11], act[10], act[9:8], act[7:0],
                     exp[12], exp[11], exp[10], exp[9:8], exp[7:0]);
        end
    endtask

    task automatic apply(input logic [3:0] d, input logic c);
        @(negedge clk);
        din = d;
        clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic apply2(input logic [3:0] d);
        @(negedge clk);
        din2 = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] ecnt;
        rst_n = 1'b0;
        din   = 4'd0;
        clr   = 1'b0;
        din2  = 4'd0;
        clr2  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        cmp("reset", 0, {locked, seq_done, err, err_code, seq_cnt}, pack(0, 0, 0, 2'd0, 8'd0));
        cmp("reset2", 0, {locked2, seq_done2, err2, err_code2, seq_cnt2}, pack(0, 0, 0, 2'd0, 8'd0));
        rst_n = 1'b1;

        // Four legal sequences with default lengths.
        push(1, 4'd0, 0, 1, 0, 0, 2'd0, 8'd0);
        for (int s = 0; s < 4; s++) begin
            push(5, 4'd1, 0, 1, 0, 0, 2'd0, 8'(s));
            push(7, 4'd2, 0, 1, 0, 0, 2'd0, 8'(s));
            push(1, 4'd0, 0, 1, 1, 0, 2'd0, 8'(s + 1));
        end
        // S1 held 6 cycles, then recovery.
        push(6, 4'd1, 0, 1, 0, 0, 2'd0, 8'd4);
        push(1, 4'd2, 0, 0, 0, 1, 2'd2, 8'd4);
        push(6, 4'd2, 0, 0, 0, 0, 2'd2, 8'd4);
        push(1, 4'd0, 0, 1, 0, 0, 2'd2, 8'd4);
        push(5, 4'd1, 0, 1, 0, 0, 2'd2, 8'd4);
        push(7, 4'd2, 0, 1, 0, 0, 2'd2, 8'd4);
        push(1, 4'd0, 0, 1, 1, 0, 2'd2, 8'd5);
        // Illegal code inside S2.
        push(5, 4'd1, 0, 1, 0, 0, 2'd2, 8'd5);
        push(3, 4'd2, 0, 1, 0, 0, 2'd2, 8'd5);
        push(1, 4'd9, 0, 0, 0, 1, 2'd0, 8'd5);
        push(1, 4'd2, 0, 0, 0, 0, 2'd0, 8'd5);
        push(1, 4'd0, 0, 1, 0, 0, 2'd0, 8'd5);
        // Direct 0->2 jump while locked.
        push(1, 4'd2, 0, 0, 0, 1, 2'd1, 8'd5);
        push(1, 4'd0, 0, 1, 0, 0, 2'd1, 8'd5);
        // One-cycle glitch back to S1 from S2.
        push(5, 4'd1, 0, 1, 0, 0, 2'd1, 8'd5);
        push(2, 4'd2, 0, 1, 0, 0, 2'd1, 8'd5);
        push(1, 4'd1, 0, 0, 0, 1, 2'd1, 8'd5);
        push(1, 4'd0, 0, 1, 0, 0, 2'd1, 8'd5);
        // Clear coincident with seq_done.
        push(5, 4'd1, 0, 1, 0, 0, 2'd1, 8'd5);
        push(7, 4'd2, 0, 1, 0, 0, 2'd1, 8'd5);
        push(1, 4'd0, 1, 1, 1, 0, 2'd0, 8'd0);
        push(1, 4'd0, 0, 1, 0, 0, 2'd0, 8'd0);

        foreach (tbl[i]) begin
            apply(tbl[i].din, tbl[i].clr);
            cmp("vec", i, {locked, seq_done, err, err_code, seq_cnt},
                pack(tbl[i].lk, tbl[i].dn, tbl[i].er, tbl[i].code, tbl[i].cnt));
        end

        // Saturation of seq_cnt over 300 sequences.
        ecnt = 8'd0;
        for (int s = 0; s < 300; s++) begin
            repeat (5) apply(4'd1, 0);
            repeat (7) apply(4'd2, 0);
            apply(4'd0, 0);
            if (ecnt != 8'd255) ecnt = ecnt + 8'd1;
            cmp("sat", s, {locked, seq_done, err, err_code, seq_cnt}, pack(1, 1, 0, 2'd0, ecnt));
        end

        // S1 held 261 cycles: saturated dwell must not alias back to 5.
        repeat (261) apply(4'd1, 0);
        cmp("dwell_sat_hold", 0, {locked, seq_done, err, err_code, seq_cnt}, pack(1, 0, 0, 2'd0, 8'd255));
        apply(4'd2, 0);
        cmp("dwell_sat_err", 0, {locked, seq_done, err, err_code, seq_cnt}, pack(0, 0, 1, 2'd2, 8'd255));
        apply(4'd0, 0);
        cmp("dwell_sat_relock", 0, {locked, seq_done, err, err_code, seq_cnt}, pack(1, 0, 0, 2'd2, 8'd255));

        // Asynchronous reset in the middle of S2.
        repeat (5) apply(4'd1, 0);
        repeat (3) apply(4'd2, 0);
        cmp("pre_rst", 0, {locked, seq_done, err, err_code, seq_cnt}, pack(1, 0, 0, 2'd2, 8'd255));
        #2;
        rst_n = 1'b0;
        #1;
        cmp("async_rst", 0, {locked, seq_done, err, err_code, seq_cnt}, pack(0, 0, 0, 2'd0, 8'd0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply(4'd2, 0);
        cmp("post_rst_s2", 0, {locked, seq_done, err, err_code, seq_cnt}, pack(0, 0, 0, 2'd0, 8'd0));
        apply(4'd1, 0);
        cmp("post_rst_s1", 0, {locked, seq_done, err, err_code, seq_cnt}, pack(0, 0, 0, 2'd0, 8'd0));
        apply(4'd0, 0);
        cmp("post_rst_lock", 0, {locked, seq_done, err, err_code, seq_cnt}, pack(1, 0, 0, 2'd0, 8'd0));
        repeat (5) apply(4'd1, 0);
        repeat (7) apply(4'd2, 0);
        apply(4'd0, 0);
        cmp("post_rst_done", 0, {locked, seq_done, err, err_code, seq_cnt}, pack(1, 1, 0, 2'd0, 8'd1));

        // Second instance with S1_LEN=3, S2_LEN=2.
        apply2(4'd0);
        cmp("p2_lock", 0, {locked2, seq_done2, err2, err_code2, seq_cnt2}, pack(1, 0, 0, 2'd0, 8'd0));
        for (int s = 0; s < 2; s++) begin
            repeat (3) apply2(4'd1);
            repeat (2) apply2(4'd2);
            cmp("p2_s2", s, {locked2, seq_done2, err2, err_code2, seq_cnt2}, pack(1, 0, 0, 2'd0, 8'(s)));
            apply2(4'd0);
            cmp("p2_done", s, {locked2, seq_done2, err2, err_code2, seq_cnt2}, pack(1, 1, 0, 2'd0, 8'(s + 1)));
        end
        repeat (3) apply2(4'd1);
        repeat (3) apply2(4'd2);
        apply2(4'd0);
        cmp("p2_s2_len", 0, {locked2, seq_done2, err2, err_code2, seq_cnt2}, pack(0, 0, 1, 2'd3, 8'd2));
        apply2(4'd0);
        cmp("p2_relock", 0, {locked2, seq_done2, err2, err_code2, seq_cnt2}, pack(1, 0, 0, 2'd3, 8'd2));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
